cache_data_array: RTL and testbench

Clocked, multi-way successor to the single-array cache data store. It holds `2**INDEX_LENGTH` sets × `WAYS` lines of `DATA_LENGTH` bits, each line with its own valid bit. It serves read, byte-masked write, deload (read-then-invalidate) and whole-array flush through a one-request-per-cycle valid/ready port. It sits between the cache controller (tag compare and way select) and the refill path.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way_bank.sv | 61 ++++++
 rtl/cache_data_array.sv | 131 +++++++++++++
 tb/tb_cache_data_array.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache data store.
//   op_e     - request operation encoding carried on op_i
//   state_e  - array controller states (sweep clear / serving requests)
//   way_width - width of a way select, never less than one bit
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_DELOAD = 2'b10,
        OP_FLUSH  = 2'b11
    } op_e;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_way_bank.sv
// cache_way_bank: storage for one way of the cache data array.
//   clk, rst           - clock, synchronous active-high reset (read regs only)
//   clr_en, clr_idx    - force line clr_idx to RESET_VALUE and invalid
//   wr_en, wr_idx,
//   wr_be, wr_data     - byte-enabled write; always marks the line valid
//   rd_en, rd_idx      - capture line contents into the read registers
//   rd_data, rd_valid  - registered read result, held until the next rd_en
module cache_way_bank #(
    parameter int                      INDEX_LENGTH = 4,
    parameter int                      DATA_LENGTH  = 32,
    parameter logic [DATA_LENGTH-1:0]  RESET_VALUE  = '0,
    localparam int                     BE_W         = DATA_LENGTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_en,
    input  logic [INDEX_LENGTH-1:0]   clr_idx,
    input  logic                      wr_en,
    input  logic [INDEX_LENGTH-1:0]   wr_idx,
    input  logic [BE_W-1:0]           wr_be,
    input  logic [DATA_LENGTH-1:0]    wr_data,
    input  logic                      rd_en,
    input  logic [INDEX_LENGTH-1:0]   rd_idx,
    output logic [DATA_LENGTH-1:0]    rd_data,
    output logic                      rd_valid
);

    localparam int SETS = 2 ** INDEX_LENGTH;

    logic [DATA_LENGTH-1:0] mem [SETS];
    logic [SETS-1:0]        vld;

    // NOTE: the array and valid vector carry no reset; the controller's
    // clear sweep initialises every line, which keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= RESET_VALUE;
            vld[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
            vld[wr_idx] <= 1'b1;
        end
    end

    // NOTE: non-blocking assignment means a deload read on the same edge
    // as its clear captures the pre-clear contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= RESET_VALUE;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_data  <= mem[rd_idx];
            rd_valid <= vld[rd_idx];
        end
    end

endmodule

// File: rtl/cache_data_array.sv
// cache_data_array: multi-way cache data store with a valid/ready request port.
//   clk, rst              - clock, synchronous active-high reset
//   req_valid_i/ready_o   - request handshake; ready only outside a clear sweep
//   op_i                  - READ / WRITE / DELOAD / FLUSH
//   index_i, way_i        - line address
//   data_i, be_i          - write data and byte enables
//   rsp_valid_o           - one-cycle strobe for READ/DELOAD responses
//   data_o, line_valid_o  - response payload, held between responses
//   busy_o                - clear sweep in progress
module cache_data_array
    import cache_pkg::*;
#(
    parameter int                      INDEX_LENGTH = 4,
    parameter int                      DATA_LENGTH  = 32,
    parameter int                      WAYS         = 2,
    parameter logic [DATA_LENGTH-1:0]  RESET_VALUE  = '0,
    localparam int                     WL           = way_width(WAYS),
    localparam int                     BE_W         = DATA_LENGTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                op_i,
    input  logic [INDEX_LENGTH-1:0]   index_i,
    input  logic [WL-1:0]             way_i,
    input  logic [DATA_LENGTH-1:0]    data_i,
    input  logic [BE_W-1:0]           be_i,
    output logic                      rsp_valid_o,
    output logic [DATA_LENGTH-1:0]    data_o,
    output logic                      line_valid_o,
    output logic                      busy_o
);

    localparam logic [INDEX_LENGTH-1:0] LAST_IDX = '1;

    state_e                  state, state_nxt;
    logic [INDEX_LENGTH-1:0] clr_idx;
    op_e                     op;
    logic                    accept, sweep, rd_accept, way_oor;
    logic [WAYS-1:0]         way_sel;
    logic                    rsp_valid_q, rsp_oor_q;
    logic [WL-1:0]           rsp_way_q;
    logic [DATA_LENGTH-1:0]  bank_data [WAYS];
    logic [WAYS-1:0]         bank_valid;

    assign op        = op_e'(op_i);
    // Reset dominates: nothing presented during rst touches storage.
    assign accept    = req_valid_i && (state == ST_READY) && !rst;
    assign sweep     = (state == ST_CLEAR) && !rst;
    assign rd_accept = accept && (op == OP_READ || op == OP_DELOAD);
    // A way number with no matching bank is ignored by every operation.
    assign way_oor   = ~|way_sel;

    // NOTE: every output of this block is defaulted first so no path
    // through the case leaves a value unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                busy_o = 1'b1;
                if (clr_idx == LAST_IDX) state_nxt = ST_READY;
            end
            ST_READY: begin
                req_ready_o = 1'b1;
                if (req_valid_i && op == OP_FLUSH) state_nxt = ST_CLEAR;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            clr_idx     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= '0;
            rsp_oor_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Wraps to 0 on the last index, so a later FLUSH starts at 0.
            clr_idx     <= (state == ST_CLEAR) ? clr_idx + INDEX_LENGTH'(1) : '0;
            rsp_valid_q <= rd_accept;
            if (rd_accept) begin
                rsp_way_q <= way_i;
                rsp_oor_q <= way_oor;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_sel[w] = (way_i == WL'(w));

        // The sweep and deload share the clear port; they never coincide
        // because requests are only accepted outside the sweep.
        cache_way_bank #(
            .INDEX_LENGTH (INDEX_LENGTH),
            .DATA_LENGTH  (DATA_LENGTH),
            .RESET_VALUE  (RESET_VALUE)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .clr_en   (sweep || (accept && op == OP_DELOAD && way_sel[w])),
            .clr_idx  (sweep ? clr_idx : index_i),
            .wr_en    (accept && op == OP_WRITE && way_sel[w]),
            .wr_idx   (index_i),
            .wr_be    (be_i),
            .wr_data  (data_i),
            .rd_en    (rd_accept && way_sel[w]),
            .rd_idx   (index_i),
            .rd_data  (bank_data[w]),
            .rd_valid (bank_valid[w])
        );
    end

    // Only the selected bank's read registers move on an accept, and
    // rsp_way_q only moves with them, so the payload holds between responses.
    always_comb begin
        data_o       = RESET_VALUE;
        line_valid_o = 1'b0;
        if (!rsp_oor_q) begin
            data_o       = bank_data[rsp_way_q];
            line_valid_o = bank_valid[rsp_way_q];
        end
    end

    assign rsp_valid_o = rsp_valid_q && !rst;

endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array: randomized scoreboard bench for cache_data_array.
// Stimulus pushes expected responses from a set/way array model; a monitor
// pops and compares whenever rsp_valid_o is high.
module tb_cache_data_array;

    localparam int IL   = 4;
    localparam int DL   = 32;
    localparam int WAYS = 2;
    localparam int SETS = 2 ** IL;
    localparam logic [DL-1:0] RV = '0;

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, DLD = 2'b10, FL = 2'b11;

    logic          clk, rst;
    logic          req_valid_i, req_ready_o;
    logic [1:0]    op_i;
    logic [IL-1:0] index_i;
    logic [0:0]    way_i;
    logic [DL-1:0] data_i;
    logic [3:0]    be_i;
    logic          rsp_valid_o, line_valid_o, busy_o;
    logic [DL-1:0] data_o;

    cache_data_array #(
        .INDEX_LENGTH (IL),
        .DATA_LENGTH  (DL),
        .WAYS         (WAYS),
        .RESET_VALUE  (RV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_i         (op_i),
        .index_i      (index_i),
        .way_i        (way_i),
        .data_i       (data_i),
        .be_i         (be_i),
        .rsp_valid_o  (rsp_valid_o),
        .data_o       (data_o),
        .line_valid_o (line_valid_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DL-1:0] data;
        logic          valid;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DL-1:0] model_data  [SETS][WAYS];
    logic          model_valid [SETS][WAYS];
    logic [DL-1:0] last_data;
    logic          last_valid;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_all();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                model_data[s][w]  = RV;
                model_valid[s][w] = 1'b0;
            end
    endtask

    // Drive one request at the negedge, wait (bounded) for ready, update the
    // model as of the accept edge, and return just after that edge.
    task automatic issue(input logic [1:0] op, input int idx, input int way,
                         input logic [DL-1:0] d, input logic [3:0] be, output int waits);
        rsp_t r;
        @(negedge clk);
        req_valid_i = 1'b1;
        op_i        = op;
        index_i     = IL'(idx);
        way_i       = 1'(way);
        data_i      = d;
        be_i        = be;
        waits       = 0;
        while (!req_ready_o && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready_o) begin
            check("ready_timeout", 64'(req_ready_o), 64'd1);
            req_valid_i = 1'b0;
            return;
        end
        case (op)
            RD, DLD: begin
                r.data  = model_data[idx][way];
                r.valid = model_valid[idx][way];
                exp_q.push_back(r);
                if (op == DLD) begin
                    model_data[idx][way]  = RV;
                    model_valid[idx][way] = 1'b0;
                end
            end
            WR: begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_data[idx][way][b*8 +: 8] = d[b*8 +: 8];
                model_valid[idx][way] = 1'b1;
            end
            default: model_clear_all();
        endcase
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    // Called one step after rst release: counts busy cycles until ready.
    task automatic measure_sweep(input string name);
        int n = 0;
        while (busy_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'd16);
        check({name, "_ready"}, 64'(req_ready_o), 64'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            last_data  = RV;
            last_valid = 1'b0;
        end else if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got data %0h with no expected response at %0t", data_o, $time);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", 64'(data_o), 64'(e.data));
                check("rsp_line_valid", 64'(line_valid_o), 64'(e.valid));
                last_data  = e.data;
                last_valid = e.valid;
            end
        end else begin
            check("hold_data", 64'(data_o), 64'(last_data));
            check("hold_line_valid", 64'(line_valid_o), 64'(last_valid));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        rst = 1'b1;
        req_valid_i = 1'b0;
        op_i = RD; index_i = '0; way_i = '0; data_i = '0; be_i = '0;
        model_clear_all();

        // Reset values and sweep length.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_data", 64'(data_o), 64'(RV));
        check("rst_line_valid", 64'(line_valid_o), 64'd0);
        rst = 1'b0;
        #1;
        measure_sweep("reset_sweep");

        // Freshly cleared lines read as RESET_VALUE / invalid.
        for (int i = 0; i < 6; i++)
            issue(RD, $urandom_range(SETS-1), $urandom_range(WAYS-1), '0, '0, w);

        // Write/read, other way invalid.
        issue(WR, 5, 1, 32'hDEADBEEF, 4'b1111, w);
        issue(RD, 5, 1, '0, '0, w);
        issue(RD, 5, 0, '0, '0, w);

        // Byte mask.
        issue(WR, 2, 0, 32'h11223344, 4'b1111, w);
        issue(WR, 2, 0, 32'hAABBCCDD, 4'b0101, w);
        issue(RD, 2, 0, '0, '0, w);

        // Deload then immediate read.
        issue(DLD, 5, 1, '0, '0, w);
        issue(RD, 5, 1, '0, '0, w);

        // Streaming WRITE/READ on one set without stalls.
        for (int i = 0; i < 20; i++) begin
            issue((i % 2 == 0) ? WR : RD, 9, 1, 32'h1000 + 32'(i / 2), 4'hF, w);
            check("stream_no_stall", 64'(w), 64'd0);
        end

        // Flush: 16 not-ready cycles, then everything invalid.
        issue(WR, 3, 0, 32'hCAFE0001, 4'hF, w);
        issue(WR, 15, 1, 32'hCAFE0002, 4'hF, w);
        issue(RD, 3, 0, '0, '0, w);
        issue(FL, 0, 0, '0, '0, w);
        @(negedge clk);
        n = 0;
        while (!req_ready_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("flush_not_ready_cycles", 64'(n), 64'd16);
        issue(RD, 3, 0, '0, '0, w);
        issue(RD, 15, 1, '0, '0, w);

        // Reset part-way through a flush sweep restarts it.
        issue(WR, 7, 1, 32'h5A5A5A5A, 4'hF, w);
        issue(FL, 0, 0, '0, '0, w);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        measure_sweep("midsweep_reset");
        issue(RD, 7, 1, '0, '0, w);

        // Randomized mix, occasional flush.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(99);
            op = (r < 2) ? FL : (r < 40) ? WR : (r < 80) ? RD : DLD;
            issue(op, $urandom_range(SETS-1), $urandom_range(WAYS-1), $urandom, 4'($urandom), w);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
